pipe_stage_reg: RTL and testbench
=================================

// Module: pipe_stage_reg
// PURPOSE
//  Parametrised pipeline-boundary register; generalises the fixed IF/ID latch to any stage boundary.
//  Carries a WIDTH-bit payload through STAGES register slices with valid/ready handshake, back-pressure and flush.
//  Instantiated between IF/ID, ID/EX, EX/MEM and MEM/WB; upstream stage drives in_*, downstream consumes out_*.
// PARAMETERS
//  WIDTH   64  payload bits (IF/ID: {inst[31:0], pc_addr[31:0]}, inst in MSBs)
//  STAGES  1   register slices in series; legal range 1..4
// PORTS
//  clk        in   1      clock, all state updates on posedge
//  rst        in   1      reset, asynchronous, active-high
//  flush      in   1      synchronous squash of all held entries (branch/exception redirect)
//  in_valid   in   1      upstream payload valid
//  in_ready   out  1      block can accept this cycle
//  in_data    in   WIDTH  upstream payload
//  out_valid  out  1      payload at output valid
//  out_ready  in   1      downstream accepts this cycle
//  out_data   out  WIDTH  payload to downstream
// BEHAVIOUR
//  - Transfer = valid & ready on the same posedge, both ports; no payload lost or duplicated.
//  - Reset (async, while rst=1): every slice EMPTY, out_valid=0, out_data=0, skid regs=0; in_ready=1.
//  - Latency: accepted word reaches out_valid STAGES cycles later with out_ready held 1; throughput 1 word/cycle.
//  - out_data and out_valid stay stable while out_valid=1 & out_ready=0.
//  - Per-slice FSM: EMPTY, FULL, SKID (SKID only with PIPE_STAGE_SKID_EN).
//    EMPTY: accept -> FULL.
//    FULL: pop & accept -> FULL (new data); pop only -> EMPTY; accept & no pop -> SKID (skid) / illegal (no skid).
//    SKID: slice in_ready=0; pop -> FULL (skid word moves to main reg, order kept).
//  - flush=1 at posedge: all slices -> EMPTY, main and skid data cleared to 0 (bubble = zero word);
//    word offered same cycle dropped; flush overrides accept and pop; out_valid=0 next cycle.
//  - out_valid=1 & out_ready=1 during flush: that output transfer still counts (downstream owns gating).
//  - rst asserted mid-transfer: state cleared immediately, no transfer completes that edge.
//  - Slices chained in_* -> out_*; inner handshakes identical to external ones.
// CONFIGURATION
//  PIPE_STAGE_SKID_EN defined: each slice has a one-entry skid buffer;
//    in_ready is a register (= slice not in SKID), no combinational out_ready->in_ready path.
//  PIPE_STAGE_SKID_EN undefined: no skid reg; in_ready = out_ready | ~out_valid (combinational path,
//    full throughput, fewer flops). Port list, latency and flush behaviour identical in both builds.
// STRUCTURE
//  - Package pipe_pkg: ifid_payload_t struct {inst, pc_addr}, IFID_W=64, slice_state_e {EMPTY,FULL,SKID};
//    width taken from COMMON_WIDTH in common_def.h.
//  - Sub-module pipe_slice (one slice: FSM, main reg, optional skid reg); top is a generate loop of
//    STAGES pipe_slice instances plus port wiring.
// TESTING
//  1 Reset: rst=1 mid-stream -> out_valid=0, out_data=0, in_ready=1 same cycle; after release accepts.
//  2 Streaming STAGES=2, out_ready=1: send 0x0000_0013_0000_1000..+4 over 8 cycles -> same 8 words in order, first
//    out_valid 2 cycles after first accept, no gaps.
//  3 Back-pressure: out_ready=0 for 3 cycles mid-stream -> out_data stable; SKID build: in_ready drops 1 cycle after
//    slice fills; non-SKID build: in_ready=0 same cycle; no loss/duplication once out_ready=1.
//  4 Flush while full (SKID state, STAGES=1): flush=1 with in_valid=1 -> next cycle out_valid=0, out_data=0,
//    in_ready=1; flushed and offered words never appear.
//  5 Random valid/ready (50%/50%, 10k cycles, both builds) -> scoreboard order match; SKID build: no comb
//    in_ready dependence on out_ready (checked by assertion).
//  6 STAGES=4 latency: single word 0xDEAD_BEEF_0000_0040 -> out_valid exactly 4 cycles after accept.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types for pipeline-boundary registers (IF/ID payload layout, slice states).
// COMMON_WIDTH, when defined, overrides the IF/ID field width.
`ifndef COMMON_WIDTH
`define COMMON_WIDTH 32
`endif

package pipe_pkg;

  localparam int unsigned XLEN = `COMMON_WIDTH;

  localparam int unsigned IFID_W = 2 * XLEN;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc_addr;
  } ifid_payload_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } slice_state_e;

endpackage

// File: rtl/pipe_slice.sv
// One valid/ready register slice; with PIPE_STAGE_SKID_EN it adds a one-entry skid
// buffer so in_ready comes straight from a flop.
module pipe_slice
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH = IFID_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  slice_state_e     state_q;
  logic             valid_q;
  logic [WIDTH-1:0] main_q;
  logic             push_c;
  logic             pop_c;

  assign push_c    = in_valid & in_ready;
  assign pop_c     = valid_q & out_ready;
  assign out_valid = valid_q;
  assign out_data  = main_q;

`ifdef PIPE_STAGE_SKID_EN
  logic [WIDTH-1:0] skid_q;
  logic             ready_q;

  assign in_ready = ready_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      main_q  <= '0;
      skid_q  <= '0;
    end else if (flush) begin
      state_q <= EMPTY;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push_c) begin
            state_q <= FULL;
            valid_q <= 1'b1;
            main_q  <= in_data;
          end
        end
        FULL: begin
          if (push_c && pop_c) begin
            main_q <= in_data;
          end else if (pop_c) begin
            state_q <= EMPTY;
            valid_q <= 1'b0;
          end else if (push_c) begin
            // Downstream stalled: park the new word, stop accepting next cycle
            state_q <= SKID;
            skid_q  <= in_data;
            ready_q <= 1'b0;
          end
        end
        SKID: begin
          if (pop_c) begin
            state_q <= FULL;
            main_q  <= skid_q;
            skid_q  <= '0;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= EMPTY;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end
`else
  // Full throughput without a skid entry: a full slice frees up as it drains
  assign in_ready = out_ready | ~valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      valid_q <= 1'b0;
      main_q  <= '0;
    end else if (flush) begin
      state_q <= EMPTY;
      valid_q <= 1'b0;
      main_q  <= '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push_c) begin
            state_q <= FULL;
            valid_q <= 1'b1;
            main_q  <= in_data;
          end
        end
        FULL: begin
          if (push_c) begin
            main_q <= in_data;
          end else if (pop_c) begin
            state_q <= EMPTY;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= EMPTY;
          valid_q <= 1'b0;
        end
      endcase
    end
  end
`endif

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline-boundary register: STAGES pipe_slice instances in series.
// Build option PIPE_STAGE_SKID_EN selects skid-buffered slices with registered in_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH  = IFID_W,
  parameter int unsigned STAGES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  for (genvar g = 0; g < STAGES; g++) begin : g_slice
    logic             up_valid;
    logic             up_ready;
    logic [WIDTH-1:0] up_data;
    logic             dn_valid;
    logic             dn_ready;
    logic [WIDTH-1:0] dn_data;

    pipe_slice #(
      .WIDTH(WIDTH)
    ) u_slice (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .in_valid (up_valid),
      .in_ready (up_ready),
      .in_data  (up_data),
      .out_valid(dn_valid),
      .out_ready(dn_ready),
      .out_data (dn_data)
    );

    // Per-slice signals keep the ready chain free of self-referencing vectors
    if (g == 0) begin : g_head
      assign up_valid = in_valid;
      assign up_data  = in_data;
      assign in_ready = up_ready;
    end else begin : g_link
      assign up_valid = g_slice[g-1].dn_valid;
      assign up_data  = g_slice[g-1].dn_data;
    end

    if (g == STAGES - 1) begin : g_tail
      assign dn_ready  = out_ready;
      assign out_valid = dn_valid;
      assign out_data  = dn_data;
    end else begin : g_mid
      assign dn_ready = g_slice[g+1].up_ready;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: three instances (STAGES = 1, 2, 4) with a queue scoreboard,
// a streaming vector table and directed back-pressure / flush / reset / latency sequences.
module tb_pipe_stage_reg;

  localparam int unsigned NDUT = 3;
  localparam int unsigned W    = 64;
`ifdef PIPE_STAGE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic         clk;
  logic         rst;
  logic         flush;
  logic         iv   [NDUT];
  logic         ir   [NDUT];
  logic [W-1:0] id   [NDUT];
  logic         ov   [NDUT];
  logic         ordy [NDUT];
  logic [W-1:0] od   [NDUT];

  logic [W-1:0] exp_q [NDUT][$];
  logic         hold  [NDUT];
  int           n_chk;
  int           n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    pipe_stage_reg #(
      .WIDTH (W),
      .STAGES(1 << g)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .in_valid (iv[g]),
      .in_ready (ir[g]),
      .in_data  (id[g]),
      .out_valid(ov[g]),
      .out_ready(ordy[g]),
      .out_data (od[g])
    );
  end

  typedef struct {
    logic         iv;
    logic [W-1:0] data;
    logic         ordy;
    logic         e_ir;
    logic         e_ov;
    logic [W-1:0] e_od;
  } vec_t;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk64(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural model: a FIFO of accepted words, updated from the handshakes about to complete
  task automatic observe(input int d);
    int cap;
    cap = (1 << d) * (SKID ? 2 : 1);
    if (rst) begin
      exp_q[d].delete();
      hold[d] = 1'b0;
      return;
    end
    if (exp_q[d].size() == 0) chk1($sformatf("idle_in_ready[%0d]", d), ir[d], 1'b1);
    if (hold[d]) chk1($sformatf("stall_valid[%0d]", d), ov[d], 1'b1);
    if (ov[d]) begin
      if (exp_q[d].size() == 0) begin
        chk1($sformatf("spurious_valid[%0d]", d), ov[d], 1'b0);
      end else begin
        chk64($sformatf("sb_data[%0d]", d), od[d], exp_q[d][0]);
        if (ordy[d]) void'(exp_q[d].pop_front());
      end
    end
    hold[d] = ov[d] & ~ordy[d] & ~flush;
    if (flush) exp_q[d].delete();
    else if (iv[d] && ir[d]) exp_q[d].push_back(id[d]);
    chk1($sformatf("capacity[%0d]", d), exp_q[d].size() > cap, 1'b0);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic adv();
    for (int d = 0; d < NDUT; d++) observe(d);
    @(negedge clk);
  endtask

  task automatic set_idle();
    flush = 1'b0;
    for (int d = 0; d < NDUT; d++) begin
      iv[d]   = 1'b0;
      id[d]   = '0;
      ordy[d] = 1'b1;
    end
  endtask

  task automatic chk_reset_state(input string tag);
    for (int d = 0; d < NDUT; d++) begin
      chk1($sformatf("%s_in_ready[%0d]", tag, d), ir[d], 1'b1);
      chk1($sformatf("%s_out_valid[%0d]", tag, d), ov[d], 1'b0);
      chk64($sformatf("%s_out_data[%0d]", tag, d), od[d], '0);
    end
  endtask

  initial begin
    vec_t         tbl [10];
    logic [W-1:0] base;
    logic [W-1:0] a, b;
    logic         ir_s [NDUT];

    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b1;
    set_idle();
    for (int d = 0; d < NDUT; d++) hold[d] = 1'b0;

    base = 64'h0000_0013_0000_1000;
    for (int i = 0; i < 10; i++) begin
      tbl[i].iv   = (i < 8);
      tbl[i].data = (i < 8) ? base + W'(4 * i) : '0;
      tbl[i].ordy = 1'b1;
      tbl[i].e_ir = 1'b1;
      tbl[i].e_ov = (i >= 2);
      tbl[i].e_od = (i >= 2) ? base + W'(4 * (i - 2)) : '0;
    end

    settle();
    chk_reset_state("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Streaming through STAGES=2: two-cycle latency, no gaps
    for (int i = 0; i < 10; i++) begin
      iv[1]   = tbl[i].iv;
      id[1]   = tbl[i].data;
      ordy[1] = tbl[i].ordy;
      settle();
      chk1($sformatf("stream_in_ready_%0d", i), ir[1], tbl[i].e_ir);
      chk1($sformatf("stream_out_valid_%0d", i), ov[1], tbl[i].e_ov);
      if (tbl[i].e_ov) chk64($sformatf("stream_out_data_%0d", i), od[1], tbl[i].e_od);
      adv();
    end
    set_idle();

    // STAGES=4 latency
    iv[2] = 1'b1;
    id[2] = 64'hDEAD_BEEF_0000_0040;
    settle();
    chk1("lat4_accept", ir[2], 1'b1);
    adv();
    iv[2] = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      settle();
      chk1($sformatf("lat4_valid_c%0d", k), ov[2], (k == 4));
      if (k == 4) chk64("lat4_data", od[2], 64'hDEAD_BEEF_0000_0040);
      adv();
    end

    // Back-pressure on STAGES=1
    a = 64'hAAAA_0001_0000_0010;
    b = 64'hBBBB_0002_0000_0020;
    iv[0] = 1'b1; id[0] = a; ordy[0] = 1'b0;
    settle();
    chk1("bp_c0_in_ready", ir[0], 1'b1);
    chk1("bp_c0_out_valid", ov[0], 1'b0);
    adv();
    id[0] = b;
    settle();
    chk1("bp_c1_out_valid", ov[0], 1'b1);
    chk64("bp_c1_out_data", od[0], a);
    chk1("bp_c1_in_ready", ir[0], SKID);
    adv();
    for (int c = 2; c <= 3; c++) begin
      iv[0] = ~SKID;
      settle();
      chk1($sformatf("bp_c%0d_out_valid", c), ov[0], 1'b1);
      chk64($sformatf("bp_c%0d_out_data", c), od[0], a);
      chk1($sformatf("bp_c%0d_in_ready", c), ir[0], 1'b0);
      adv();
    end
    ordy[0] = 1'b1;
    settle();
    chk64("bp_c4_out_data", od[0], a);
    chk1("bp_c4_in_ready", ir[0], ~SKID);
    adv();
    iv[0] = 1'b0;
    settle();
    chk1("bp_c5_out_valid", ov[0], 1'b1);
    chk64("bp_c5_out_data", od[0], b);
    chk1("bp_c5_in_ready", ir[0], 1'b1);
    adv();
    settle();
    chk1("bp_c6_out_valid", ov[0], 1'b0);
    adv();

    // Flush while full/skid on STAGES=1; offered word in the flush cycle is dropped
    iv[0] = 1'b1; id[0] = 64'hF1F1_0000_0000_0001; ordy[0] = 1'b0;
    settle();
    adv();
    id[0] = 64'hF2F2_0000_0000_0002;
    settle();
    adv();
    id[0] = 64'hF3F3_0000_0000_0003;
    flush = 1'b1;
    settle();
    chk1("flush_pre_valid", ov[0], 1'b1);
    adv();
    flush = 1'b0;
    iv[0] = 1'b0;
    settle();
    chk1("flush_out_valid", ov[0], 1'b0);
    chk64("flush_out_data", od[0], '0);
    chk1("flush_in_ready", ir[0], 1'b1);
    adv();
    ordy[0] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      settle();
      chk1($sformatf("flush_no_ghost_%0d", c), ov[0], 1'b0);
      adv();
    end

    // Reset asserted mid-stream on STAGES=2
    for (int i = 0; i < 3; i++) begin
      iv[1] = 1'b1;
      id[1] = 64'h1111_0000_0000_0000 + W'(i);
      settle();
      adv();
    end
    rst = 1'b1;
    settle();
    chk_reset_state("midrst");
    adv();
    rst   = 1'b0;
    id[1] = 64'h5555_0000_0000_0055;
    settle();
    chk1("post_rst_accept", ir[1], 1'b1);
    adv();
    iv[1] = 1'b0;
    settle();
    adv();
    settle();
    chk1("post_rst_valid", ov[1], 1'b1);
    chk64("post_rst_data", od[1], 64'h5555_0000_0000_0055);
    adv();

    // Random valid/ready/flush traffic on all instances
    for (int cyc = 0; cyc < 10000; cyc++) begin
      flush = ($urandom_range(0, 49) == 0);
      for (int d = 0; d < NDUT; d++) begin
        iv[d]   = 1'($urandom_range(0, 1));
        ordy[d] = 1'($urandom_range(0, 1));
        id[d]   = {$urandom(), $urandom()};
      end
      settle();
`ifdef PIPE_STAGE_SKID_EN
      for (int d = 0; d < NDUT; d++) begin
        ir_s[d] = ir[d];
        ordy[d] = ~ordy[d];
      end
      #1;
      for (int d = 0; d < NDUT; d++) begin
        chk1($sformatf("ready_path[%0d]", d), ir[d], ir_s[d]);
        ordy[d] = ~ordy[d];
      end
      #1;
`endif
      adv();
    end

    set_idle();
    for (int c = 0; c < 12; c++) begin
      settle();
      adv();
    end
    for (int d = 0; d < NDUT; d++)
      chk1($sformatf("drain_empty[%0d]", d), exp_q[d].size() == 0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
